// File: rtl/dm_load_if.sv
// Load-unit bus bundle: pipeline request, data-memory read port and response channel.
interface dm_load_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_type;
  logic          flush;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_exc;

  modport master (
    output req_valid, req_addr, req_type, flush, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_exc
  );

  modport slave (
    input  req_valid, req_addr, req_type, flush, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_exc
  );
endinterface

// File: rtl/dm_load_unit.sv
// Data-memory load unit: issues one word read per load, extracts/extends the result.
// Define DM_LOAD_ALIGN_CHECK_EN to flag misaligned LW/LH/LHU as AdEL without a memory read.
module dm_load_unit (
  input  logic      clk,
  input  logic      reset,
  dm_load_if.slave  bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;

  localparam logic [TW-1:0] T_LW  = 6'b000110;
  localparam logic [TW-1:0] T_LH  = 6'b010001;
  localparam logic [TW-1:0] T_LHU = 6'b010010;
  localparam logic [TW-1:0] T_LB  = 6'b010101;
  localparam logic [TW-1:0] T_LBU = 6'b010110;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] type_q, type_d;
  logic          rd_en_q, rd_en_d;
  logic          ready_q, ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          exc_q, exc_d;

  logic          misaligned_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [DW-1:0] extract_c;

`ifdef DM_LOAD_ALIGN_CHECK_EN
  always_comb begin
    misaligned_c = 1'b0;
    case (bus.req_type)
      T_LW:        misaligned_c = |bus.req_addr[1:0];
      T_LH, T_LHU: misaligned_c = bus.req_addr[0];
      default:     misaligned_c = 1'b0;
    endcase
  end
`else
  assign misaligned_c = 1'b0;
`endif

  // Lane selection uses the latched address; unknown types pass the raw word through.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_c = bus.mem_rdata[7:0];
      2'd1:    byte_c = bus.mem_rdata[15:8];
      2'd2:    byte_c = bus.mem_rdata[23:16];
      default: byte_c = bus.mem_rdata[31:24];
    endcase
    half_c = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (type_q)
      T_LW:    extract_c = bus.mem_rdata;
      T_LH:    extract_c = {{16{half_c[15]}}, half_c};
      T_LHU:   extract_c = {16'h0000, half_c};
      T_LB:    extract_c = {{24{byte_c[7]}}, byte_c};
      T_LBU:   extract_c = {24'h000000, byte_c};
      default: extract_c = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic; flush dominates every state.
  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    type_d       = type_q;
    rd_en_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    data_d       = data_q;
    exc_d        = exc_q;
    if (bus.flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      exc_d        = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_d = bus.req_addr;
            type_d = bus.req_type;
            if (misaligned_c) begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
              data_d       = '0;
              exc_d        = 1'b1;
            end else begin
              state_d = WAIT_MEM;
              rd_en_d = 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            data_d       = extract_c;
            exc_d        = 1'b0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            exc_d        = 1'b0;
          end
        end
        default: begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          exc_d        = 1'b0;
        end
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      type_q       <= '0;
      rd_en_q      <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      data_q       <= '0;
      exc_q        <= 1'b0;
    end else begin
      state        <= state_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      rd_en_q      <= rd_en_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      data_q       <= data_d;
      exc_q        <= exc_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = {addr_q[AW-1:2], 2'b00};
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_exc   = exc_q;
endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: directed corner cases plus randomized loads against a reference model.
module tb_dm_load_unit;
  localparam logic [5:0] T_LW  = 6'b000110;
  localparam logic [5:0] T_LH  = 6'b010001;
  localparam logic [5:0] T_LHU = 6'b010010;
  localparam logic [5:0] T_LB  = 6'b010101;
  localparam logic [5:0] T_LBU = 6'b010110;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dm_load_if bus ();

  dm_load_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: shift the word down to the addressed lane, mask, then extend arithmetically.
  function automatic void ref_load(input logic [5:0] t, input logic [31:0] a,
                                   input logic [31:0] w, output bit mis, output logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] b;
    logic [31:0] h;
    sh  = 32'(a[1:0]) * 32'd8;
    b   = (w >> sh) & 32'h0000_00FF;
    h   = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
    mis = 1'b0;
    if (t == T_LW) begin
      d = w;
      mis = (a % 32'd4) != 32'd0;
    end else if (t == T_LH) begin
      d = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      mis = (a % 32'd2) != 32'd0;
    end else if (t == T_LHU) begin
      d = h;
      mis = (a % 32'd2) != 32'd0;
    end else if (t == T_LB) begin
      d = (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
    end else if (t == T_LBU) begin
      d = b;
    end else begin
      d = w;
    end
`ifndef DM_LOAD_ALIGN_CHECK_EN
    mis = 1'b0;
`endif
    if (mis) d = 32'h0;
  endfunction

  task automatic accept(input logic [5:0] t, input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_type  = t;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
  endtask

  task automatic run_load(input logic [5:0] t, input logic [31:0] a, input logic [31:0] w,
                          input int rv_dly, input int rdy_dly);
    bit          mis;
    logic [31:0] exp_d;
    ref_load(t, a, w, mis, exp_d);
    accept(t, a);
    if (mis) begin
      check("no_rd_en_misaligned", 32'(bus.mem_rd_en), 32'd0);
    end else begin
      check("rd_en", 32'(bus.mem_rd_en), 32'd1);
      check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      check("resp_valid_wait", 32'(bus.resp_valid), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
        bus.mem_rdata = $urandom;
        tick();
        check("rd_en_single", 32'(bus.mem_rd_en), 32'd0);
        check("resp_valid_wait", 32'(bus.resp_valid), 32'd0);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = w;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_data", bus.resp_data, exp_d);
    check("resp_exc", 32'(bus.resp_exc), 32'(mis));
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
      check("resp_data_hold", bus.resp_data, exp_d);
      check("resp_exc_hold", 32'(bus.resp_exc), 32'(mis));
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("resp_valid_done", 32'(bus.resp_valid), 32'd0);
    check("resp_exc_done", 32'(bus.resp_exc), 32'd0);
    check("req_ready_done", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] types [6];
    logic [5:0] t;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_type   = '0;
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);

    // Directed extraction and handshake cases
    run_load(T_LB, 32'h0000_0003, 32'h80FF_1234, 0, 0);
    run_load(T_LHU, 32'h0000_0002, 32'h8001_7FFF, 0, 0);
    run_load(T_LH, 32'h0000_0002, 32'h8001_7FFF, 1, 0);
    run_load(T_LW, 32'h0000_0010, 32'hCAFE_F00D, 3, 2);
    run_load(T_LW, 32'h0000_0006, 32'h1357_9BDF, 0, 1);
    run_load(6'b111111, 32'h0000_0001, 32'hA5A5_5A5A, 0, 0);

    // Stray rvalid while idle is ignored
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    check("idle_rvalid_ignored", 32'(bus.resp_valid), 32'd0);
    check("idle_rvalid_ready", 32'(bus.req_ready), 32'd1);

    // Flush while waiting for memory, late rvalid discarded
    accept(T_LW, 32'h0000_0020);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_wait_ready", 32'(bus.req_ready), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    tick();
    bus.mem_rvalid = 1'b0;
    check("flush_late_rvalid", 32'(bus.resp_valid), 32'd0);
    check("flush_late_ready", 32'(bus.req_ready), 32'd1);

    // Flush together with a request drops the request
    bus.req_valid = 1'b1;
    bus.req_type  = T_LW;
    bus.req_addr  = 32'h0000_0040;
    bus.flush     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    check("flush_req_no_rd", 32'(bus.mem_rd_en), 32'd0);
    check("flush_req_ready", 32'(bus.req_ready), 32'd1);

    // Flush in RESP clears the response
    accept(T_LW, 32'h0000_0044);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_8888;
    tick();
    bus.mem_rvalid = 1'b0;
    check("pre_flush_valid", 32'(bus.resp_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("flush_resp_exc", 32'(bus.resp_exc), 32'd0);
    check("flush_resp_ready", 32'(bus.req_ready), 32'd1);

    // Reset in RESP with resp_ready low
    accept(T_LW, 32'h0000_0048);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    tick();
    bus.mem_rvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_resp_valid2", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data2", bus.resp_data, 32'h0);
    check("rst_req_ready2", 32'(bus.req_ready), 32'd1);
    check("rst_mem_addr2", bus.mem_addr, 32'h0);

    // Reset in WAIT_MEM, later rvalid ignored
    accept(T_LW, 32'h0000_004C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rst_wait_rvalid", 32'(bus.resp_valid), 32'd0);
    check("rst_wait_ready", 32'(bus.req_ready), 32'd1);

    // Randomized loads
    types[0] = T_LW;
    types[1] = T_LH;
    types[2] = T_LHU;
    types[3] = T_LB;
    types[4] = T_LBU;
    for (int n = 0; n < 80; n++) begin
      types[5] = 6'($urandom);
      t = types[$urandom_range(5, 0)];
      run_load(t, $urandom, $urandom, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dm_load_unit.md
DM_LOAD_UNIT -- requirements
Module: dm_load_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset, named as in the codebase: clk, reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  1  load request from the pipeline (MEM stage).
REQ-005 Port: req_ready  output  1  block can accept a request this cycle.
REQ-006 Port: req_addr  input  32  byte address of the load.
REQ-007 Port: req_type  input  6  load kind: LW=6'b000110, LH=6'b010001, LHU=6'b010010, LB=6'b010101, LBU=6'b010110.
REQ-008 Port: flush  input  1  abort the in-flight load and drop its result.
REQ-009 Port: mem_rd_en  output  1  one-cycle read strobe to data memory.
REQ-010 Port: mem_addr  output  32  word-aligned read address, {addr[31:2],2'b00}.
REQ-011 Port: mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-012 Port: mem_rdata  input  32  raw memory word.
REQ-013 Port: resp_valid  output  1  resp_data/resp_exc are valid.
REQ-014 Port: resp_ready  input  1  consumer accepts the response.
REQ-015 Port: resp_data  output  32  extracted, extended load result.
REQ-016 Port: resp_exc  output  1  address-error-on-load flag (AdEL).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_MEM and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid=1 SHALL latch req_addr and req_type into internal registers.
REQ-019 On acceptance of an aligned request, mem_rd_en SHALL be 1 for exactly the next cycle with mem_addr from the latched address, and the FSM SHALL enter WAIT_MEM.
REQ-020 In WAIT_MEM, mem_rvalid=1 SHALL register the extracted result into resp_data and move to RESP; mem_rvalid in any other state SHALL be ignored.
REQ-021 Extraction: LW the whole word; LH/LHU halfword at bits [31:16] if addr[1]=1 else [15:0]; LB/LBU byte at bits [8*addr[1:0]+7 : 8*addr[1:0]].
REQ-022 LH and LB SHALL sign-extend to 32 bits; LHU and LBU SHALL zero-extend.
REQ-023 Any other req_type SHALL be accepted and SHALL return the raw memory word with resp_exc=0.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_data/resp_exc SHALL be stable until resp_ready=1, which returns the FSM to IDLE the following cycle.
REQ-025 Minimum latency SHALL be: request accepted in cycle N, mem_rd_en in N+1, resp_valid in the cycle after mem_rvalid.
REQ-026 A new request SHALL NOT be accepted in the same cycle a response is consumed (no back-to-back overlap).
REQ-027 flush=1 SHALL return the FSM to IDLE next cycle from any state, deassert resp_valid, and discard any later mem_rvalid for the flushed load.
REQ-028 flush=1 together with req_valid=1 in IDLE SHALL drop the request (flush has priority).
REQ-029 resp_exc SHALL be 0 whenever resp_valid is 0.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, mem_rd_en=0, resp_valid=0, resp_data=32'h0, resp_exc=0, latched address/type=0, overriding flush and all requests.
REQ-031 Reset asserted mid-transaction SHALL discard the in-flight load; a mem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-032 Macro DM_LOAD_ALIGN_CHECK_EN SHALL control misalignment detection.
REQ-033 With DM_LOAD_ALIGN_CHECK_EN defined: LW with addr[1:0]!=0, or LH/LHU with addr[0]=1, SHALL skip the memory read (mem_rd_en stays 0), go directly to RESP next cycle with resp_exc=1, resp_data=32'h0.
REQ-034 Without DM_LOAD_ALIGN_CHECK_EN: low address bits SHALL be ignored for alignment (LW uses the word, LH uses addr[1]), every load reads memory, and resp_exc SHALL be tied to 0.

Verification
REQ-035 LB addr=32'h0000_0003, mem_rdata=32'h80FF_1234 -> resp_data=32'hFFFF_FF80, resp_exc=0.
REQ-036 LHU addr=32'h0000_0002, mem_rdata=32'h8001_7FFF -> resp_data=32'h0000_8001; LH same -> 32'hFFFF_8001.
REQ-037 LW addr=32'h0000_0010, mem_rvalid delayed 3 cycles, resp_ready low 2 cycles -> mem_addr=32'h10, resp_data held stable, single handshake.
REQ-038 With DM_LOAD_ALIGN_CHECK_EN: LW addr=32'h0000_0006 -> no mem_rd_en, resp_exc=1, resp_data=0; without macro -> memory read at 32'h4, resp_exc=0.
REQ-039 flush in WAIT_MEM then mem_rvalid next cycle -> FSM in IDLE, resp_valid never asserted, req_ready=1.
REQ-040 reset asserted in RESP with resp_ready=0 -> next cycle resp_valid=0, resp_data=0, req_ready=1.
